// File: rtl/bank_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bank_stream_reader                                               |
// | Purpose : Reads N coefficients from the interleaved coefficient banks and  |
// |           emits them in index order on a valid/ready stream.               |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module bank_stream_reader #(
  parameter int N          = 256,
  parameter int NUM_BANK   = 4,
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  output logic                       busy,
  output logic                       done,
  output logic                       bank_en,
  output logic [NUM_BANK-1:0]        bank_ren,
  output logic [ADDR_W-1:0]          bank_raddr,
  input  logic [NUM_BANK*DATA_W-1:0] bank_q,
  output logic [DATA_W-1:0]          out_data,
  output logic [7:0]                 out_idx,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int c_IW = $clog2(N);
  localparam int c_BW = $clog2(NUM_BANK);
  localparam int c_PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CW = $clog2(FIFO_DEPTH + 1) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  logic [ADDR_W-1:0]    r_base;
  logic [c_IW-1:0]      r_issue_idx;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_bank_en;
  logic [NUM_BANK-1:0]  r_bank_ren;
  logic [ADDR_W-1:0]    r_bank_raddr;

  // Stage a travels with the read request, stage b with the returned bank Q.
  logic                 r_a_v;
  logic [c_BW-1:0]      r_a_bank;
  logic [7:0]           r_a_idx;
  logic                 r_a_last;
  logic                 r_b_v;
  logic [c_BW-1:0]      r_b_bank;
  logic [7:0]           r_b_idx;
  logic                 r_b_last;

  logic [DATA_W-1:0]    r_mem_data [FIFO_DEPTH];
  logic [7:0]           r_mem_idx  [FIFO_DEPTH];
  logic                 r_mem_last [FIFO_DEPTH];
  logic [c_PW-1:0]      r_wptr;
  logic [c_PW-1:0]      r_rptr;
  logic [c_CW-1:0]      r_count;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_credit;
  logic                 w_last_issue;
  logic [c_BW-1:0]      w_issue_bank;
  logic [ADDR_W-1:0]    w_issue_row;
  logic [DATA_W-1:0]    w_q_sel;

  assign out_valid    = (r_count != '0);
  assign out_data     = r_mem_data[r_rptr];
  assign out_idx      = r_mem_idx[r_rptr];
  assign out_last     = r_mem_last[r_rptr];
  assign busy         = r_busy;
  assign done         = r_done;
  assign bank_en      = r_bank_en;
  assign bank_ren     = r_bank_ren;
  assign bank_raddr   = r_bank_raddr;

  assign w_push       = r_b_v;
  assign w_pop        = out_valid & out_ready;
  // Reads already requested or returning count against the FIFO space.
  assign w_credit     = (r_count + c_CW'(r_a_v) + c_CW'(r_b_v)) < c_CW'(FIFO_DEPTH);
  assign w_last_issue = (r_issue_idx == c_IW'(N - 1));
  assign w_issue_bank = r_issue_idx[c_BW-1:0];
  assign w_issue_row  = ADDR_W'(r_issue_idx >> c_BW);

  always_comb begin
    w_q_sel = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      if (r_b_bank == c_BW'(b)) begin
        w_q_sel = bank_q[b*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_issue_idx  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_bank_en    <= 1'b0;
      r_bank_ren   <= '0;
      r_bank_raddr <= '0;
      r_a_v        <= 1'b0;
      r_a_bank     <= '0;
      r_a_idx      <= '0;
      r_a_last     <= 1'b0;
      r_b_v        <= 1'b0;
      r_b_bank     <= '0;
      r_b_idx      <= '0;
      r_b_last     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_bank_ren <= '0;
      r_a_v      <= 1'b0;
      r_b_v      <= r_a_v;
      r_b_bank   <= r_a_bank;
      r_b_idx    <= r_a_idx;
      r_b_last   <= r_a_last;
      case (r_state)
        S_IDLE: begin
          // Index 0 is requested on the accepting edge to reach the 2-cycle latency.
          if (start) begin
            r_base       <= base_addr;
            r_busy       <= 1'b1;
            r_bank_en    <= 1'b1;
            r_bank_ren   <= NUM_BANK'(1);
            r_bank_raddr <= base_addr;
            r_a_v        <= 1'b1;
            r_a_bank     <= '0;
            r_a_idx      <= '0;
            r_a_last     <= 1'b0;
            r_issue_idx  <= c_IW'(1);
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_credit) begin
            r_bank_ren   <= NUM_BANK'(1) << w_issue_bank;
            r_bank_raddr <= r_base + w_issue_row;
            r_a_v        <= 1'b1;
            r_a_bank     <= w_issue_bank;
            r_a_idx      <= 8'(r_issue_idx);
            r_a_last     <= w_last_issue;
            r_issue_idx  <= r_issue_idx + c_IW'(1);
            if (w_last_issue) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // The last-tagged entry is the final one, so its pop empties everything.
          if (w_pop && out_last) begin
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_bank_en <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        r_mem_data[e] <= '0;
        r_mem_idx[e]  <= '0;
        r_mem_last[e] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_mem_data[r_wptr] <= w_q_sel;
        r_mem_idx[r_wptr]  <= r_b_idx;
        r_mem_last[r_wptr] <= r_b_last;
        r_wptr <= (r_wptr == c_PW'(FIFO_DEPTH - 1)) ? '0 : r_wptr + c_PW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == c_PW'(FIFO_DEPTH - 1)) ? '0 : r_rptr + c_PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bank_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_bank_stream_reader                                            |
// | Purpose : Scoreboard bench for bank_stream_reader with a registered bank   |
// |           model and directed readout scenarios.                            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_bank_stream_reader;

  localparam int c_N     = 256;
  localparam int c_DEPTH = 4;

  typedef struct packed {
    logic [11:0] data;
    logic [7:0]  idx;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  base_addr = '0;
  logic        busy, done, bank_en;
  logic [3:0]  bank_ren;
  logic [6:0]  bank_raddr;
  logic [47:0] bank_q = '0;
  logic [11:0] out_data;
  logic [7:0]  out_idx;
  logic        out_last, out_valid;
  logic        out_ready = 1'b1;

  beat_t       exp_q[$];
  logic [11:0] mem [4][128];
  int n_checks = 0, n_fail = 0;
  int issue_cnt = 0, issued_total = 0, popped_total = 0;
  int beats_seen = 0, done_cnt = 0, exp_base = 0;
  int ready_mode = 1;
  int cyc = 0, hs_first = 0, hs_last = 0;

  bank_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .bank_en(bank_en), .bank_ren(bank_ren),
    .bank_raddr(bank_raddr), .bank_q(bank_q), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Preload pattern: {bank[1:0], 3'b101, addr[6:0]}.
  function automatic logic [11:0] coef(input int b, input int a);
    return 12'((b << 10) | (5 << 7) | a);
  endfunction

  initial begin
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 128; a++)
        mem[b][a] = coef(b, a);
  end

  // Registered bank model: Q holds the read only in the cycle after IREN, noise otherwise.
  initial begin : bank_model
    logic [3:0] cap_ren;
    logic [6:0] cap_a;
    logic       cap_en;
    forever begin
      @(negedge clk);
      cap_ren = bank_ren;
      cap_a   = bank_raddr;
      cap_en  = bank_en;
      @(posedge clk);
      #1;
      for (int b = 0; b < 4; b++)
        bank_q[b*12 +: 12] = (cap_en && cap_ren[b]) ? mem[b][cap_a] : 12'($urandom);
    end
  end

  initial begin : ready_drv
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : monitor
    beat_t       e;
    logic        cur_hs, prev_v, prev_r, prev_last_hs, prev_l;
    logic [11:0] prev_d;
    logic [7:0]  prev_i;
    int          k;
    prev_v = 0; prev_r = 0; prev_last_hs = 0; prev_l = 0; prev_d = '0; prev_i = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_v = 0;
        prev_last_hs = 0;
      end else begin
        chk("done_pulse", 32'(done), 32'(prev_last_hs));
        if (done) done_cnt++;
        if (prev_v && !prev_r) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_data", 32'(out_data), 32'(prev_d));
          chk("hold_idx", 32'(out_idx), 32'(prev_i));
          chk("hold_last", 32'(out_last), 32'(prev_l));
        end
        if (bank_ren != 4'd0) begin
          k = issue_cnt;
          chk("issue_ren", 32'(bank_ren), 32'(1 << (k % 4)));
          chk("issue_raddr", 32'(bank_raddr), 32'((exp_base + k / 4) % 128));
          chk("issue_en", 32'(bank_en), 32'd1);
          issue_cnt++;
          issued_total++;
        end
        chk("outstanding_le_depth", (issued_total - popped_total <= c_DEPTH) ? 32'd1 : 32'd0, 32'd1);
        cur_hs = out_valid && out_ready;
        if (cur_hs) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat_idx", 32'(out_idx), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", 32'(out_data), 32'(e.data));
            chk("beat_idx", 32'(out_idx), 32'(e.idx));
            chk("beat_last", 32'(out_last), 32'(e.last));
          end
          if (out_idx == 8'd0) hs_first = cyc;
          if (out_last) hs_last = cyc;
          popped_total++;
          beats_seen++;
        end
        prev_last_hs = cur_hs && out_last;
        prev_v = out_valid; prev_r = out_ready;
        prev_d = out_data;  prev_i = out_idx;  prev_l = out_last;
      end
    end
  end

  task automatic begin_run(input int base);
    @(posedge clk);
    #1;
    exp_q.delete();
    for (int i = 0; i < c_N; i++) begin
      beat_t e;
      e.data = coef(i % 4, (base + i / 4) % 128);
      e.idx  = 8'(i);
      e.last = (i == c_N - 1);
      exp_q.push_back(e);
    end
    exp_base = base; issue_cnt = 0; beats_seen = 0; done_cnt = 0;
    start = 1'b1;
    base_addr = 7'(base);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    for (int c = 0; c < 4000 && beats_seen < n; c++) @(negedge clk);
    chk("beats_reached", (beats_seen >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    for (int c = 0; c < 4000 && done_cnt == 0; c++) @(negedge clk);
    chk("done_seen", (done_cnt >= 1) ? 32'd1 : 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    chk("single_done", 32'(done_cnt), 32'd1);
    chk("beats_total", 32'(beats_seen), 32'(c_N));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("busy_low_after", 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_bank_en"}, 32'(bank_en), 32'd0);
    chk({tag, "_bank_ren"}, 32'(bank_ren), 32'd0);
    chk({tag, "_bank_raddr"}, 32'(bank_raddr), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_out_idx"}, 32'(out_idx), 32'd0);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    #12;
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: base 0, ready high: latency, back-to-back beats, last/done placement
    ready_mode = 1;
    begin_run(0);
    @(negedge clk);
    chk("t1_busy_rise", 32'(busy), 32'd1);
    chk("t1_valid_c0", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_c1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_c2", 32'(out_valid), 32'd1);
    chk("t1_first_idx", 32'(out_idx), 32'd0);
    chk("t1_first_data", 32'(out_data), 32'h280);
    wait_done();
    chk("t1_consecutive", 32'(hs_last - hs_first), 32'(c_N - 1));

    // 2: base 100, addresses wrap past 127
    begin_run(100);
    wait_done();

    // 3: random backpressure
    ready_mode = 2;
    begin_run(17);
    wait_done();

    // 4: ready low for 20 cycles, only FIFO_DEPTH reads may be issued
    ready_mode = 0;
    repeat (2) @(posedge clk);
    begin_run(5);
    repeat (20) @(negedge clk);
    chk("t4_issue_stall", 32'(issue_cnt), 32'(c_DEPTH));
    chk("t4_valid_held", 32'(out_valid), 32'd1);
    chk("t4_head_idx", 32'(out_idx), 32'd0);
    ready_mode = 1;
    wait_done();

    // 5: start while busy is ignored
    begin_run(0);
    wait_beats(50);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 7'd77;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();

    // 6: async reset mid-readout, then a fresh full readout
    ready_mode = 2;
    begin_run(0);
    wait_beats(100);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6_async");
    exp_q.delete();
    issue_cnt = 0; issued_total = 0; popped_total = 0; beats_seen = 0; done_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_no_done", 32'(done_cnt), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    begin_run(0);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
